// File: rtl/lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : RV32I load/store unit; one outstanding bus access, IDLE/WAIT/DONE.
// Revision : 1.0
// ============================================================================
module lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        lsu_stall,
    output logic        lsu_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lane;

    logic        w_legal;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_load_fmt;
    logic        w_issue;
    logic        w_ack_done;
    logic        w_timeout;

    always_comb begin
        w_legal = 1'b0;
        case (Funct3M)
            3'd0, 3'd4: w_legal = 1'b1;
            3'd1, 3'd5: w_legal = ~ALUResultM[0];
            3'd2:       w_legal = (ALUResultM[1:0] == 2'b00);
            default:    w_legal = 1'b0;
        endcase
    end

    // Funct3M[1:0] encodes the access size for both loads and stores.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = WriteDataM;
        case (Funct3M[1:0])
            2'd0: begin
                w_be    = 4'b0001 << ALUResultM[1:0];
                w_wdata = {4{WriteDataM[7:0]}};
            end
            2'd1: begin
                w_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{WriteDataM[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = WriteDataM;
            end
        endcase
    end

    always_comb begin
        w_shifted  = dmem_rdata >> {r_lane, 3'b000};
        w_load_fmt = dmem_rdata;
        case (r_funct3)
            3'd0:    w_load_fmt = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'd4:    w_load_fmt = {24'd0, w_shifted[7:0]};
            3'd1:    w_load_fmt = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'd5:    w_load_fmt = {16'd0, w_shifted[15:0]};
            default: w_load_fmt = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        lsu_stall    = 1'b0;
        lsu_err      = 1'b0;
        ReadDataM    = 32'd0;
        w_issue      = 1'b0;
        w_ack_done   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (MemReqM) begin
                    if (w_legal) begin
                        lsu_stall    = 1'b1;
                        w_issue      = 1'b1;
                        w_state_next = WAIT;
                    end else begin
                        lsu_err = 1'b1;
                    end
                end
            end
            WAIT: begin
                lsu_stall = 1'b1;
                if (dmem_ack) begin
                    w_ack_done   = 1'b1;
                    w_state_next = DONE;
                end else if (r_cnt == c_timeout_last) begin
                    w_timeout    = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                ReadDataM    = r_rdata;
                lsu_err      = r_err;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= 8'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= 32'd0;
            r_be     <= 4'd0;
            r_wdata  <= 32'd0;
            r_funct3 <= 3'd0;
            r_lane   <= 2'd0;
        end else begin
            if (w_issue) begin
                r_cnt    <= 8'd0;
                r_rdata  <= 32'd0;
                r_err    <= 1'b0;
                r_req    <= 1'b1;
                r_we     <= MemWriteM;
                r_addr   <= {ALUResultM[31:2], 2'b00};
                r_be     <= w_be;
                r_wdata  <= MemWriteM ? w_wdata : 32'd0;
                r_funct3 <= Funct3M;
                r_lane   <= ALUResultM[1:0];
            end
            if (w_ack_done) begin
                r_req   <= 1'b0;
                r_rdata <= r_we ? 32'd0 : w_load_fmt;
            end else if (w_timeout) begin
                r_req   <= 1'b0;
                r_rdata <= 32'd0;
                r_err   <= 1'b1;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (r_state == DONE) begin
                r_rdata <= 32'd0;
                r_err   <= 1'b0;
            end
        end
    end

    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_be    = r_be;
    assign dmem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Purpose  : Randomized scoreboard bench for lsu with a bus responder model.
// Revision : 1.0
// ============================================================================
module tb_lsu;
    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReqM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM, ReadDataM;
    logic        lsu_stall, lsu_err;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;

    always #5 clk = ~clk;

    lsu #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .MemReqM(MemReqM), .MemWriteM(MemWriteM),
        .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .lsu_stall(lsu_stall), .lsu_err(lsu_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata)
    );

    typedef struct {
        logic        legal;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdm;
        logic        err;
        int          stalls;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    int          tb_delay = 0;
    logic [31:0] tb_rdata = 32'd0;
    logic        force_ack = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus slave: acks after tb_delay non-ack request cycles (never if negative);
    // outside a request it toggles ack randomly, which the LSU must ignore.
    int req_seen = 0;
    always @(negedge clk) begin
        if (force_ack) begin
            dmem_ack   = 1'b1;
            dmem_rdata = $urandom;
        end else if (dmem_req === 1'b1) begin
            dmem_ack   = (tb_delay >= 0) && (req_seen == tb_delay);
            dmem_rdata = dmem_ack ? tb_rdata : $urandom;
            req_seen++;
        end else begin
            req_seen   = 0;
            dmem_ack   = 1'($urandom_range(0, 1));
            dmem_rdata = $urandom;
        end
    end

    int          m_stalls = 0;
    int          m_rises = 0;
    logic        m_prev_req = 1'b0;
    logic        m_stable = 1'b1;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic        m_we;

    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            m_stalls = 0; m_rises = 0; m_prev_req = 1'b0; m_stable = 1'b1;
        end else begin
            if (dmem_req) begin
                if (!m_prev_req) begin
                    m_rises++;
                    m_addr = dmem_addr; m_be = dmem_be; m_we = dmem_we; m_wdata = dmem_wdata;
                end else if (dmem_addr !== m_addr || dmem_be !== m_be ||
                             dmem_we !== m_we || dmem_wdata !== m_wdata) begin
                    m_stable = 1'b0;
                end
            end
            m_prev_req = dmem_req;
            if (MemReqM && lsu_stall) begin
                m_stalls++;
                check("err_while_stalled", 32'(lsu_err), 32'd0);
            end else if (MemReqM) begin
                if (sb_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_completion: got completion expected none");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("read_data", ReadDataM, e.rdm);
                    check("lsu_err", 32'(lsu_err), 32'(e.err));
                    check("stall_cycles", 32'(m_stalls), 32'(e.stalls));
                    check("request_count", 32'(m_rises), e.legal ? 32'd1 : 32'd0);
                    if (e.legal) begin
                        check("dmem_addr", m_addr, e.addr);
                        check("dmem_be", 32'(m_be), 32'(e.be));
                        check("dmem_we", 32'(m_we), 32'(e.we));
                        check("bus_stable", 32'(m_stable), 32'd1);
                        if (e.we) check("dmem_wdata", m_wdata, e.wdata);
                    end
                end
                m_stalls = 0; m_rises = 0; m_stable = 1'b1;
            end else begin
                check("idle_stall", 32'(lsu_stall), 32'd0);
                check("idle_read_data", ReadDataM, 32'd0);
                check("idle_err", 32'(lsu_err), 32'd0);
            end
        end
    end

    // Reference model: size from funct3, lane from the two low address bits.
    task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd, input int delay);
        exp_t        e;
        logic [31:0] lane_data;
        int          lane;
        int          n;
        bit          timed_out;
        lane      = int'(addr[1:0]);
        lane_data = rd >> (8 * lane);
        timed_out = (delay < 0) || (delay >= TIMEOUT);
        e.we      = we;
        e.addr    = addr & 32'hFFFF_FFFC;
        case (f3)
            3'd0, 3'd4: e.legal = 1'b1;
            3'd1, 3'd5: e.legal = (lane % 2 == 0);
            3'd2:       e.legal = (lane == 0);
            default:    e.legal = 1'b0;
        endcase
        case (f3 % 4)
            0: begin e.be = 4'(1 << lane); e.wdata = {4{wd[7:0]}}; end
            1: begin e.be = (lane >= 2) ? 4'hC : 4'h3; e.wdata = {2{wd[15:0]}}; end
            default: begin e.be = 4'hF; e.wdata = wd; end
        endcase
        if (!e.legal || we || timed_out) e.rdm = 32'd0;
        else begin
            case (f3)
                3'd0: e.rdm = 32'($signed(lane_data[7:0]));
                3'd4: e.rdm = 32'(lane_data[7:0]);
                3'd1: e.rdm = 32'($signed(lane_data[15:0]));
                3'd5: e.rdm = 32'(lane_data[15:0]);
                default: e.rdm = rd;
            endcase
        end
        e.err    = !e.legal || timed_out;
        e.stalls = !e.legal ? 0 : (timed_out ? 1 + TIMEOUT : 2 + delay);
        sb_q.push_back(e);
        tb_delay = delay; tb_rdata = rd;
        MemReqM = 1'b1; MemWriteM = we; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
        n = 0;
        @(negedge clk);
        while (lsu_stall && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++; failures++;
            $display("FAIL txn_timeout: got stall stuck expected release");
        end
        @(posedge clk); #1;
        MemReqM = 1'b0;
    endtask

    task automatic idle(input int cycles);
        MemReqM = 1'b0;
        repeat (cycles) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic [2:0] store_f3[8];
        store_f3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd0, 3'd1, 3'd2};
        reset = 1'b1; MemReqM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'd0;
        ALUResultM = 32'd0; WriteDataM = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_we", 32'(dmem_we), 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_be", 32'(dmem_be), 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_read_data", ReadDataM, 32'd0);
        check("rst_err", 32'(lsu_err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        do_txn(1'b0, 3'd0, 32'h0000_1003, 32'd0, 32'h80AA_55CC, 0);
        idle(3);
        do_txn(1'b1, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 32'd0, 0);
        do_txn(1'b0, 3'd5, 32'h0000_2002, 32'd0, 32'hBEEF_0000, 1);
        do_txn(1'b0, 3'd2, 32'h0000_3001, 32'd0, 32'h1111_1111, 0);
        do_txn(1'b0, 3'd3, 32'h0000_3001, 32'd0, 32'h1111_1111, 0);
        do_txn(1'b0, 3'd2, 32'h0000_4000, 32'd0, 32'h2222_2222, -1);
        idle(1);
        do_txn(1'b1, 3'd2, 32'h0000_5000, 32'hDEAD_BEEF, 32'd0, 1);
        do_txn(1'b0, 3'd2, 32'h0000_5004, 32'd0, 32'hCAFE_F00D, 1);
        do_txn(1'b0, 3'd1, 32'h0000_5006, 32'd0, 32'h8001_7FFF, TIMEOUT - 1);
        idle(2);

        // Abandon a load in its second WAIT cycle, then offer a late ack.
        MemReqM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'd2; ALUResultM = 32'h0000_6000;
        tb_delay = 2; tb_rdata = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("req_before_reset", 32'(dmem_req), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0; MemReqM = 1'b0; force_ack = 1'b1;
        @(negedge clk);
        check("req_after_reset", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        force_ack = 1'b0;
        @(negedge clk);
        check("late_ack_ignored", 32'(dmem_req), 32'd0);
        check("late_ack_read_data", ReadDataM, 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 150; i++) begin
            logic        we;
            logic [2:0]  f3;
            we = 1'($urandom_range(0, 1));
            f3 = we ? store_f3[$urandom_range(0, 7)] : 3'($urandom_range(0, 7));
            do_txn(we, f3, $urandom, $urandom, $urandom, int'($urandom_range(0, 5)) - 1);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(4);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255; max cycles waited for dmem_ack (1..255).
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port MemReqM  in  1  memory-stage instruction is a load or store.
REQ-005 SHALL have port MemWriteM  in  1  1=store, 0=load.
REQ-006 SHALL have port Funct3M  in  3  RV32I width/sign code.
REQ-007 SHALL have port ALUResultM  in  32  effective byte address.
REQ-008 SHALL have port WriteDataM  in  32  store data (rs2).
REQ-009 SHALL have port ReadDataM  out  32  formatted load result.
REQ-010 SHALL have port lsu_stall  out  1  hold pipeline.
REQ-011 SHALL have port lsu_err  out  1  one-cycle fault pulse (misalign, bad funct3, timeout).
REQ-012 SHALL have port dmem_req  out  1  bus request.
REQ-013 SHALL have port dmem_we  out  1  bus write.
REQ-014 SHALL have port dmem_addr  out  32  word address, bits[1:0]=0.
REQ-015 SHALL have port dmem_be  out  4  byte enables.
REQ-016 SHALL have port dmem_wdata  out  32  lane-aligned store data.
REQ-017 SHALL have port dmem_ack  in  1  bus completion; rdata valid same cycle.
REQ-018 SHALL have port dmem_rdata  in  32  bus read word.

Function
REQ-019 SHALL implement FSM IDLE, WAIT, DONE.
REQ-020 IDLE: MemReqM=1 and legal access -> lsu_stall=1 combinationally; bus outputs registered; next WAIT.
REQ-021 Legal: funct3 0/4 any address; 1/5 ALUResultM[0]=0; 2 only ALUResultM[1:0]=0; 3/6/7 never legal.
REQ-022 IDLE, MemReqM=1, illegal access: no bus request, lsu_stall=0, lsu_err=1 this cycle, ReadDataM=0, stay IDLE.
REQ-023 WAIT: dmem_req=1, lsu_stall=1; dmem_addr/be/we/wdata stable until ack.
REQ-024 WAIT with dmem_ack=1: capture formatted load data, drop dmem_req next cycle, go DONE.
REQ-025 WAIT: cycle counter increments per non-ack cycle; count reaching TIMEOUT -> drop request, capture 0, lsu_err=1 in DONE, go DONE.
REQ-026 DONE: lsu_stall=0, ReadDataM=captured value, unconditionally -> IDLE (no re-issue of held instruction).
REQ-027 Min latency: 3 cycles (IDLE, WAIT with ack, DONE); each extra non-ack cycle adds one.
REQ-028 Store byte enables: SB 4'b0001<<addr[1:0]; SH addr[1]?1100:0011; SW 1111; loads drive be per same rule.
REQ-029 Store data: SB byte replicated x4; SH halfword replicated x2; SW unchanged.
REQ-030 Load format: lane selected by addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend; LW whole word.
REQ-031 dmem_ack outside WAIT SHALL be ignored.
REQ-032 ReadDataM SHALL be 0 whenever state is not DONE.
REQ-033 Stores in DONE SHALL return ReadDataM=0.

Reset
REQ-034 reset at clk edge -> state IDLE, counter 0, captured data 0, dmem_req/we=0, dmem_addr/be/wdata=0.
REQ-035 reset during WAIT drops dmem_req at that edge; pending transaction abandoned; late ack ignored.
REQ-036 Outputs after reset: ReadDataM=0, lsu_err=0; lsu_stall follows REQ-020 from inputs.

Verification
REQ-037 LB addr 0x1003, rdata 0x80AA55CC, ack first WAIT cycle -> be=1000, addr 0x1000, ReadDataM=0xFFFFFF80 in DONE, 3 cycles stall-free after.
REQ-038 SH addr 0x2002, WriteDataM 0x1234ABCD -> wdata 0xABCDABCD, be=1100, we=1; LHU same addr with rdata 0xBEEF0000 -> 0x0000BEEF.
REQ-039 LW addr 0x3001 -> no dmem_req, lsu_err 1 cycle, lsu_stall 0, ReadDataM 0; funct3=3 behaves identically.
REQ-040 LW addr 0x4000, ack withheld, TIMEOUT=4 -> stall 4 WAIT cycles, DONE with lsu_err=1, ReadDataM=0, back to IDLE.
REQ-041 Reset asserted 2nd WAIT cycle, ack next cycle -> dmem_req 0 after edge, FSM IDLE, ack ignored, ReadDataM 0.
REQ-042 Back-to-back SW then LW (ack delay 2) -> no overlap; each request issued once; total 4+4 cycles.
